// File: rtl/uart_tx_fsm_if.sv
// Signal bundle between the UART TX frame controller, its request source and the
// external 8-bit serializer.
interface uart_tx_fsm_if;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_done;
    logic       ser_data;
    logic       ser_en;
    logic       busy;
    logic       TX_OUT;
    logic       frame_done;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
        input  ser_en, busy, TX_OUT, frame_done
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
        output ser_en, busy, TX_OUT, frame_done
    );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: start bit, 8 serialized data bits, optional parity,
// then STOP_BITS stop cycles on TX_OUT.
module uart_tx_fsm #(
    parameter int unsigned STOP_BITS = 1
) (
    input logic          CLK,
    input logic          RST,
    uart_tx_fsm_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    localparam logic [1:0] StopLast = 2'(STOP_BITS - 1);

    state_e     state_q, state_d;
    logic [1:0] stop_cnt_q, stop_cnt_d;
    logic       par_bit_q, par_bit_d;
    logic       par_en_q, par_en_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            stop_cnt_q <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stop_cnt_q <= stop_cnt_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stop_cnt_d = stop_cnt_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        unique case (state_q)
            StIdle: begin
                // Parity and enable are frozen here so later input changes can't leak in.
                if (bus.Data_Valid) begin
                    par_bit_d = bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    state_d   = StStart;
                end
            end
            StStart: state_d = StData;
            StData: begin
                if (bus.ser_done) begin
                    state_d = par_en_q ? StParity : StStop;
                end
            end
            StParity: state_d = StStop;
            StStop: begin
                if (stop_cnt_q == StopLast) begin
                    stop_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    stop_cnt_d = stop_cnt_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.TX_OUT     = 1'b1;
        bus.busy       = 1'b1;
        bus.ser_en     = 1'b0;
        bus.frame_done = 1'b0;
        unique case (state_q)
            StIdle:   bus.busy = 1'b0;
            StStart:  bus.TX_OUT = 1'b0;
            StData: begin
                bus.TX_OUT = bus.ser_data;
                bus.ser_en = 1'b1;
            end
            StParity: bus.TX_OUT = par_bit_q;
            StStop:   bus.frame_done = (stop_cnt_q == StopLast);
            default:  bus.busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm: one instance per STOP_BITS setting, each paired with
// a small behavioural model of the external serializer.
module tb_uart_tx_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       dv;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    bit         sel = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    uart_tx_fsm_if u1 ();
    uart_tx_fsm_if u2 ();

    assign u1.P_DATA     = p_data;
    assign u1.Data_Valid = dv;
    assign u1.PAR_EN     = par_en;
    assign u1.PAR_TYP    = par_typ;
    assign u2.P_DATA     = p_data;
    assign u2.Data_Valid = dv;
    assign u2.PAR_EN     = par_en;
    assign u2.PAR_TYP    = par_typ;

    // Serializer: loads on accept, shifts while enabled, clears when enable drops.
    logic [7:0] sh1 = '0;
    logic [7:0] sh2 = '0;
    logic [2:0] c1 = '0;
    logic [2:0] c2 = '0;

    always @(posedge clk) begin
        if (dv && !u1.busy) sh1 <= p_data;
        if (u1.ser_en) c1 <= c1 + 3'd1;
        else c1 <= '0;
        if (dv && !u2.busy) sh2 <= p_data;
        if (u2.ser_en) c2 <= c2 + 3'd1;
        else c2 <= '0;
    end

    assign u1.ser_data = sh1[c1];
    assign u1.ser_done = u1.ser_en && (c1 == 3'd7);
    assign u2.ser_data = sh2[c2];
    assign u2.ser_done = u2.ser_en && (c2 == 3'd7);

    uart_tx_fsm #(.STOP_BITS(1)) dut1 (.CLK(clk), .RST(rst), .bus(u1.slave));
    uart_tx_fsm #(.STOP_BITS(2)) dut2 (.CLK(clk), .RST(rst), .bus(u2.slave));

    logic m_tx, m_busy, m_sen, m_fd;
    assign m_tx   = sel ? u2.TX_OUT     : u1.TX_OUT;
    assign m_busy = sel ? u2.busy       : u1.busy;
    assign m_sen  = sel ? u2.ser_en     : u1.ser_en;
    assign m_fd   = sel ? u2.frame_done : u1.frame_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".tx"}, 32'(m_tx), 32'd1);
        check_eq({tag, ".busy"}, 32'(m_busy), 32'd0);
        check_eq({tag, ".sen"}, 32'(m_sen), 32'd0);
        check_eq({tag, ".fd"}, 32'(m_fd), 32'd0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the START cycle.
    task automatic start_req(input logic [7:0] d, input logic pe, input logic pt);
        p_data  = d;
        par_en  = pe;
        par_typ = pt;
        dv      = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int n, input logic [15:0] exp,
                               input bit keep_dv, input bit tog, input logic pt_new);
        logic [15:0] bits = '0;
        int nbusy = 0;
        int nsen = 0;
        int nfd = 0;
        int fd_at = -1;
        if (!keep_dv) dv = 1'b0;
        for (int i = 0; i < n; i++) begin
            bits[i] = m_tx;
            if (m_busy) nbusy++;
            if (m_sen) nsen++;
            if (m_fd) begin
                nfd++;
                fd_at = i;
            end
            if (tog && i == 3) par_typ = pt_new;
            @(negedge clk);
        end
        check_eq({tag, ".bits"}, 32'(bits), 32'(exp));
        check_eq({tag, ".busy_n"}, 32'(nbusy), 32'(n));
        check_eq({tag, ".sen_n"}, 32'(nsen), 32'd8);
        check_eq({tag, ".fd_n"}, 32'(nfd), 32'd1);
        check_eq({tag, ".fd_at"}, 32'(fd_at), 32'(n - 1));
        check_eq({tag, ".idle_tx"}, 32'(m_tx), 32'd1);
        check_eq({tag, ".idle_busy"}, 32'(m_busy), 32'd0);
    endtask

    initial begin
        int nfd;
        int nbusy;
        rst     = 1'b1;
        dv      = 1'b1;
        p_data  = 8'hA5;
        par_en  = 1'b0;
        par_typ = 1'b0;

        repeat (2) begin
            @(negedge clk);
            check_idle("rst");
        end
        rst = 1'b0;
        dv  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_idle("post_rst");
        end

        start_req(8'hA5, 1'b0, 1'b0);
        check_frame("a5", 10, 16'b1101001010, 1'b0, 1'b0, 1'b0);

        start_req(8'h07, 1'b1, 1'b0);
        check_frame("p07e", 11, 16'b11000001110, 1'b0, 1'b0, 1'b0);
        start_req(8'h07, 1'b1, 1'b1);
        check_frame("p07o", 11, 16'b10000001110, 1'b0, 1'b0, 1'b0);
        start_req(8'h00, 1'b1, 1'b0);
        check_frame("p00e", 11, 16'b10000000000, 1'b0, 1'b0, 1'b0);

        // Held request: PAR_TYP flips mid-frame and applies only to the next accept.
        start_req(8'h07, 1'b1, 1'b0);
        check_frame("contA", 11, 16'b11000001110, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check_frame("contB", 11, 16'b10000001110, 1'b0, 1'b1, 1'b0);

        start_req(8'hFF, 1'b0, 1'b0);
        dv = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("mr.sen_bit4", 32'(m_sen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mr.after");
        nfd   = 0;
        nbusy = 0;
        repeat (12) begin
            @(negedge clk);
            if (m_fd) nfd++;
            if (m_busy) nbusy++;
        end
        check_eq("mr.no_fd", 32'(nfd), 32'd0);
        check_eq("mr.no_busy", 32'(nbusy), 32'd0);
        start_req(8'h3C, 1'b0, 1'b0);
        check_frame("mr.3c", 10, 16'b1001111000, 1'b0, 1'b0, 1'b0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b1;
        @(negedge clk);
        check_idle("sb2.rst");
        start_req(8'h80, 1'b1, 1'b1);
        check_frame("sb2", 12, 16'b110100000000, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
